gate_controller: RTL
====================

# gate_controller

Synchronous controller for the automated parking gate. It samples the arrival sensor, the leaving sensor and the 8-bit PIN bus, and drives the open, close, block and alarm outputs. It implements the gate-side end of the sensor/PIN interface that the existing gate test stimulus drives and observes. All outputs are registered Moore outputs of a 5-state FSM.

## Interface
- PIN, 8'h2A: correct access code (8'b00101010).
- MAX_ATTEMPTS, 3: number of consecutive wrong PIN attempts that raises the PIN alarm (1..3).
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low; one clock domain.
- asensor  in  1  arrival sensor; 1 = vehicle waiting at the gate.
- lsensor  in  1  leaving sensor; 1 = vehicle under or past the gate.
- password  in  8  PIN bus; 8'h00 = no entry.
- gate_open  out  1  gate-open command, level.
- gate_close  out  1  gate-close command, one-cycle pulse.
- gate_block  out  1  gate locked.
- p_alarm  out  1  PIN alarm, level.
- b_alarm  out  1  block (tailgate) alarm, level.

## Operation
- Attempt detection: pw_q holds the previous cycle's password (reset 8'h00).
  - attempt = (password != 0) && (password != pw_q). A held value counts once.
  - good = attempt && password == PIN; bad = attempt && password != PIN.
- Wrong-attempt counter: 2 bits, reset 0.
  - Increments on each bad in WAIT_PIN and saturates at MAX_ATTEMPTS.
  - Cleared on entry to OPEN, IDLE or BLOCKED.
- States: IDLE, WAIT_PIN, OPEN, PIN_ALARM, BLOCKED. Reset state is IDLE.
- IDLE:
  - asensor & lsensor -> BLOCKED.
  - asensor -> WAIT_PIN.
  - lsensor alone is ignored.
- WAIT_PIN:
  - lsensor -> BLOCKED (highest priority).
  - good -> OPEN.
  - bad that brings the counter to MAX_ATTEMPTS -> PIN_ALARM.
  - !asensor with no attempt this cycle -> IDLE.
  - Otherwise stay.
- OPEN:
  - lsensor & asensor -> BLOCKED (second vehicle tailgating).
  - lsensor & !asensor -> IDLE, with a one-cycle gate_close pulse.
  - password is ignored.
- PIN_ALARM:
  - lsensor -> BLOCKED.
  - good -> OPEN.
  - bad and asensor changes are ignored. The alarm holds until the correct PIN or a block.
- BLOCKED:
  - good while asensor == 0 and lsensor == 0 -> IDLE.
  - Everything else is ignored, including bad attempts, which are not counted.
- Outputs per state:
  - IDLE: all 0, except gate_close = 1 for the single cycle after leaving OPEN.
  - WAIT_PIN: all 0.
  - OPEN: gate_open = 1.
  - PIN_ALARM: p_alarm = 1.
  - BLOCKED: gate_block = 1, b_alarm = 1.
- Priority within one cycle: block condition > good > bad > sensor release.

## Timing
- Inputs are sampled on rising edge k. State, counter, pw_q and all outputs update at edge k. The response is visible one cycle after the stimulus is present.
- gate_close is high for exactly one cycle, the cycle following the OPEN->IDLE edge.
- Reset mid-operation:
  - All outputs drop to 0 immediately (asynchronously); state -> IDLE, counter = 0, pw_q = 8'h00.
  - Operation resumes on the first rising edge after rst_n returns to 1.
- A password change and a sensor change in the same cycle are resolved in one transition using the priority order above.
- Inputs are synchronous to clk; no internal synchronisers.

## Test plan
- Nominal pass:
  - Stimulus: asensor=1, then password=8'h2A, then asensor=0 with password=0, then lsensor=1.
  - Response: WAIT_PIN; gate_open=1 one cycle after 8'h2A; gate_open=0 and gate_close pulsed one cycle after lsensor; returns to IDLE.
- Two wrong, then correct:
  - Stimulus: asensor=1; password sequence 8'h2E, 8'hAA, 8'h2A.
  - Response: counter goes 1, 2; p_alarm stays 0; gate_open=1 after 8'h2A; counter=0.
- PIN alarm:
  - Stimulus: asensor=1; password sequence 8'h2E, 8'hAA, 8'hA3, 8'hAF, 8'h2A.
  - Response: p_alarm=1 one cycle after 8'hA3; it stays 1 through 8'hAF; it clears and gate_open=1 one cycle after 8'h2A.
- Tailgate block and release:
  - Stimulus: asensor=1, then lsensor=1 with asensor still 1; both sensors return to 0; password 8'h01, then 8'h2A.
  - Response: gate_block=1 and b_alarm=1 one cycle after lsensor rises; both stay 1 through 8'h01; both drop to 0 one cycle after 8'h2A; state IDLE.
- Held value counted once:
  - Stimulus: in WAIT_PIN, hold password=8'h2E for 10 cycles.
  - Response: counter=1 and no p_alarm.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously while in OPEN and while in BLOCKED.
  - Response: all outputs 0 immediately; after release, asensor=1 leads to WAIT_PIN normally.

Source files
------------

// File: rtl/gate_if.sv
// Sensor/PIN bundle between the gate stimulus side (master) and the gate controller (slave).
interface gate_if;
  logic       asensor;
  logic       lsensor;
  logic [7:0] password;
  logic       gate_open;
  logic       gate_close;
  logic       gate_block;
  logic       p_alarm;
  logic       b_alarm;

  modport master (
    output asensor, lsensor, password,
    input  gate_open, gate_close, gate_block, p_alarm, b_alarm
  );

  modport slave (
    input  asensor, lsensor, password,
    output gate_open, gate_close, gate_block, p_alarm, b_alarm
  );
endinterface

// File: rtl/gate_controller.sv
// Parking gate controller: PIN entry, gate open/close and tailgate blocking.
// Five-state Moore FSM; every output is a flop loaded from the next state.
module gate_controller #(
  parameter logic [7:0]  PIN          = 8'h2A,
  parameter int unsigned MAX_ATTEMPTS = 3
) (
  input logic  clk,
  input logic  rst_n,
  gate_if.slave gif
);

  localparam int unsigned PW_W  = 8;
  localparam int unsigned CNT_W = 2;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ATTEMPTS);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_PIN, S_OPEN, S_PIN_ALARM, S_BLOCKED
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PW_W-1:0]   pw_q, pw_d;
  logic              gate_open_q, gate_open_d;
  logic              gate_close_q, gate_close_d;
  logic              gate_block_q, gate_block_d;
  logic              p_alarm_q, p_alarm_d;
  logic              b_alarm_q, b_alarm_d;

  logic              attempt_c, good_c, bad_c;
  logic [CNT_W-1:0]  cnt_inc_c;

  // A held non-zero code counts as a single attempt.
  assign attempt_c = (gif.password != '0) && (gif.password != pw_q);
  assign good_c    = attempt_c && (gif.password == PIN);
  assign bad_c     = attempt_c && (gif.password != PIN);
  assign cnt_inc_c = cnt_q + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pw_q         <= '0;
      gate_open_q  <= 1'b0;
      gate_close_q <= 1'b0;
      gate_block_q <= 1'b0;
      p_alarm_q    <= 1'b0;
      b_alarm_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pw_q         <= pw_d;
      gate_open_q  <= gate_open_d;
      gate_close_q <= gate_close_d;
      gate_block_q <= gate_block_d;
      p_alarm_q    <= p_alarm_d;
      b_alarm_q    <= b_alarm_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pw_d         = gif.password;
    gate_close_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (gif.asensor && gif.lsensor) state_d = S_BLOCKED;
        else if (gif.asensor)           state_d = S_WAIT_PIN;
      end
      S_WAIT_PIN: begin
        if (gif.lsensor)   state_d = S_BLOCKED;
        else if (good_c)   state_d = S_OPEN;
        else if (bad_c) begin
          if (cnt_q != MAX_CNT)     cnt_d   = cnt_inc_c;
          if (cnt_inc_c == MAX_CNT) state_d = S_PIN_ALARM;
        end
        else if (!gif.asensor) state_d = S_IDLE;
      end
      S_OPEN: begin
        if (gif.lsensor && gif.asensor) state_d = S_BLOCKED;
        else if (gif.lsensor) begin
          state_d      = S_IDLE;
          gate_close_d = 1'b1;
        end
      end
      S_PIN_ALARM: begin
        if (gif.lsensor)   state_d = S_BLOCKED;
        else if (good_c)   state_d = S_OPEN;
      end
      S_BLOCKED: begin
        if (good_c && !gif.asensor && !gif.lsensor) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Attempt count only survives inside WAIT_PIN / PIN_ALARM.
    if (state_d == S_IDLE || state_d == S_OPEN || state_d == S_BLOCKED) cnt_d = '0;

    gate_open_d  = (state_d == S_OPEN);
    gate_block_d = (state_d == S_BLOCKED);
    b_alarm_d    = (state_d == S_BLOCKED);
    p_alarm_d    = (state_d == S_PIN_ALARM);
  end

  assign gif.gate_open  = gate_open_q;
  assign gif.gate_close = gate_close_q;
  assign gif.gate_block = gate_block_q;
  assign gif.p_alarm    = p_alarm_q;
  assign gif.b_alarm    = b_alarm_q;

endmodule
